muldiv_unit: RTL and testbench

- Parametrised multi-cycle RV32M/RV64M execute-stage unit: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Sits beside the ALU in the execute stage.
- Drives busy_E to the hazard unit so the pipeline stalls F/D/E while an operation is in flight, then pulses done_E with the result for forwarding into the EX/MEM register.
- Generalises the single-cycle ALU path with a configurable data width, configurable multiply latency, an iterative divider, and flush/abort behaviour.

---
 rtl/muldiv_unit.sv | 175 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// RV32M/RV64M multiply/divide unit for the execute stage (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
// Latency: multiply MUL_LAT+1 cycles, divide XLEN+1 cycles, zero-divisor/overflow 1 cycle.
// Backpressure: busy_E stalls F/D/E while an op is in flight; done_E pulses once with result_E.
module muldiv_unit #(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_E,
  input  logic [2:0]      op_E,
  input  logic [XLEN-1:0] src_a_E,
  input  logic [XLEN-1:0] src_b_E,
  input  logic            flush_E,
  output logic            busy_E,
  output logic            done_E,
  output logic [XLEN-1:0] result_E
);

  // Counter must hold both XLEN (divide iterations) and MUL_LAT-1.
  localparam int CW = $clog2(XLEN + MUL_LAT + 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [1:0]          op_q, op_d;       // op[2] is only needed at acceptance
  logic [2*XLEN-1:0]   prod_q, prod_d;
  logic [XLEN-1:0]     rem_q, rem_d;
  logic [XLEN-1:0]     quo_q, quo_d;     // holds the shifting dividend, then the quotient
  logic [XLEN-1:0]     dvs_q, dvs_d;
  logic                qneg_q, qneg_d;
  logic                rneg_q, rneg_d;
  logic [XLEN-1:0]     result_q, result_d;

  // Operand conditioning at acceptance: sign-extended multiply operands, divide magnitudes.
  logic              mul_a_s, mul_b_s, div_s, a_neg, b_neg;
  logic [2*XLEN-1:0] a_ext, b_ext, prod_full;
  logic [XLEN-1:0]   a_mag, b_mag;

  // Product is formed on 2*XLEN-wide extended operands so the high half is exact for every signedness.
  always_comb begin
    mul_a_s   = (op_E[1:0] == 2'b01) || (op_E[1:0] == 2'b10);
    mul_b_s   = (op_E[1:0] == 2'b01);
    a_ext     = {{XLEN{mul_a_s & src_a_E[XLEN-1]}}, src_a_E};
    b_ext     = {{XLEN{mul_b_s & src_b_E[XLEN-1]}}, src_b_E};
    prod_full = a_ext * b_ext;
    div_s     = ~op_E[0];
    a_neg     = div_s & src_a_E[XLEN-1];
    b_neg     = div_s & src_b_E[XLEN-1];
    a_mag     = a_neg ? -src_a_E : src_a_E;
    b_mag     = b_neg ? -src_b_E : src_b_E;
  end

  // One restoring radix-2 step; the borrow out of the XLEN+1-bit subtract is the trial result.
  logic [XLEN:0]   shifted, trial;
  logic            ge;
  logic [XLEN-1:0] rem_nxt, quo_nxt, rem_fix, quo_fix;

  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    trial   = shifted - {1'b0, dvs_q};
    ge      = ~trial[XLEN];
    rem_nxt = ge ? trial[XLEN-1:0] : shifted[XLEN-1:0];
    quo_nxt = {quo_q[XLEN-2:0], ge};
    quo_fix = qneg_q ? -quo_nxt : quo_nxt;
    rem_fix = rneg_q ? -rem_nxt : rem_nxt;
  end

  // Next-state and stall logic; flush aborts only while an op is in flight.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    prod_d   = prod_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    busy_E   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_E && !flush_E) begin
          busy_E = 1'b1;
          op_d   = op_E[1:0];
          if (!op_E[2]) begin
            prod_d  = prod_full;
            cnt_d   = CW'(MUL_LAT - 1);
            state_d = S_MUL;
          end else if (src_b_E == '0) begin
            result_d = op_E[1] ? src_a_E : '1;
            state_d  = S_DONE;
          end else if (div_s && (src_a_E == MOST_NEG) && (src_b_E == '1)) begin
            result_d = op_E[1] ? '0 : src_a_E;
            state_d  = S_DONE;
          end else begin
            rem_d   = '0;
            quo_d   = a_mag;
            dvs_d   = b_mag;
            qneg_d  = a_neg ^ b_neg;
            rneg_d  = a_neg;
            cnt_d   = CW'(XLEN);
            state_d = S_DIV;
          end
        end
      end
      S_MUL: begin
        busy_E = 1'b1;
        if (flush_E) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          result_d = (op_q == 2'b00) ? prod_q[XLEN-1:0] : prod_q[2*XLEN-1:XLEN];
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DIV: begin
        busy_E = 1'b1;
        if (flush_E) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          rem_d = rem_nxt;
          quo_d = quo_nxt;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            result_d = op_q[1] ? rem_fix : quo_fix;
            state_d  = S_DONE;
          end
        end
      end
      S_DONE: begin
        // Held start_E is ignored here so the stalled instruction cannot retrigger.
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign done_E   = (state_q == S_DONE);
  assign result_E = result_q;

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      prod_q   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      prod_q   <= prod_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: a 32-bit/MUL_LAT=2 and a 64-bit/MUL_LAT=1 instance with shared operands.
// Stimulus pushes expected result and latency; per-instance monitors pop on done_E.
module tb_muldiv_unit;

  logic        clk;
  logic        rst32, rst64, start32, start64, flush32, flush64;
  logic [2:0]  op;
  logic [63:0] a, b;
  logic        busy32, done32, busy64, done64;
  logic [31:0] res32;
  logic [63:0] res64;

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;

  typedef struct {
    logic [63:0] res;
    int          lat;
    int          t0;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];

  muldiv_unit #(.XLEN(32), .MUL_LAT(2)) u32 (
    .clk(clk), .reset(rst32), .start_E(start32), .op_E(op),
    .src_a_E(a[31:0]), .src_b_E(b[31:0]), .flush_E(flush32),
    .busy_E(busy32), .done_E(done32), .result_E(res32)
  );

  muldiv_unit #(.XLEN(64), .MUL_LAT(1)) u64 (
    .clk(clk), .reset(rst64), .start_E(start64), .op_E(op),
    .src_a_E(a), .src_b_E(b), .flush_E(flush64),
    .busy_E(busy64), .done_E(done64), .result_E(res64)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic busy_of(input bit w);
    return w ? busy64 : busy32;
  endfunction

  function automatic logic done_of(input bit w);
    return w ? done64 : done32;
  endfunction

  function automatic logic [63:0] res_of(input bit w);
    return w ? res64 : {32'b0, res32};
  endfunction

  task automatic set_start(input bit w, input logic v);
    if (w) start64 = v; else start32 = v;
  endtask

  task automatic set_flush(input bit w, input logic v);
    if (w) flush64 = v; else flush32 = v;
  endtask

  task automatic set_rst(input bit w, input logic v);
    if (w) rst64 = v; else rst32 = v;
  endtask

  // Monitors: every done_E pulse must match the oldest expectation in value and latency.
  always @(negedge clk) begin
    exp_t e;
    if (!rst32 && done32) begin
      if (q32.size() == 0) begin
        tests++; failed++;
        $display("FAIL done32_unexpected: got pulse, expected none (cycle %0d)", cyc);
      end else begin
        e = q32.pop_front();
        chk("result32", {32'b0, res32}, e.res);
        chk("latency32", 64'(cyc - e.t0), 64'(e.lat));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst64 && done64) begin
      if (q64.size() == 0) begin
        tests++; failed++;
        $display("FAIL done64_unexpected: got pulse, expected none (cycle %0d)", cyc);
      end else begin
        e = q64.pop_front();
        chk("result64", res64, e.res);
        chk("latency64", 64'(cyc - e.t0), 64'(e.lat));
      end
    end
  end

  // Issue one op in cycle 0, scramble inputs afterwards, hold start through DONE, then drop it.
  task automatic run_op(input bit w, input logic [2:0] o, input logic [63:0] x, input logic [63:0] y,
                        input logic [63:0] e, input int lat);
    exp_t s;
    op = o; a = x; b = y;
    s.res = e; s.lat = lat; s.t0 = cyc;
    if (w) q64.push_back(s); else q32.push_back(s);
    set_start(w, 1'b1);
    #1 chk("busy_cycle0", busy_of(w), 1);
    for (int n = 1; n <= lat; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin a = ~x; b = ~y; op = ~o; end
      if (n < lat) chk("busy_inflight", busy_of(w), 1);
    end
    chk("busy_in_done", busy_of(w), 0);
    chk("done_pulse", done_of(w), 1);
    @(posedge clk); #1;
    set_start(w, 1'b0);
    #1 chk("done_single", done_of(w), 0);
    @(posedge clk); #1;
  endtask

  // Flush a divide in cycle 10: no pulse, busy low from cycle 11, result held.
  task automatic flush_test(input bit w, input int xl);
    logic [63:0] prev;
    prev = res_of(w);
    op = 3'b100; a = 64'd20; b = 64'd3;
    set_start(w, 1'b1);
    repeat (10) begin @(posedge clk); #1; end
    set_flush(w, 1'b1);
    #1 chk("busy_flush_cycle", busy_of(w), 1);
    @(posedge clk); #1;
    set_start(w, 1'b0); set_flush(w, 1'b0);
    #1 chk("busy_after_flush", busy_of(w), 0);
    repeat (xl + 5) @(posedge clk);
    #1 chk("result_held_after_flush", res_of(w), prev);
  endtask

  // start_E with flush_E in IDLE must not start anything.
  task automatic idle_flush_test(input bit w);
    op = 3'b100; a = 64'd100; b = 64'd7;
    set_start(w, 1'b1); set_flush(w, 1'b1);
    #1 chk("busy_start_flush", busy_of(w), 0);
    @(posedge clk); #1;
    set_start(w, 1'b0); set_flush(w, 1'b0);
    #1 chk("no_start_after_flush", busy_of(w), 0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Asynchronous reset between edges in cycle 20 of a divide.
  task automatic reset_test(input bit w);
    op = 3'b101; a = 64'd100; b = 64'd7;
    set_start(w, 1'b1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    set_rst(w, 1'b1); set_start(w, 1'b0);
    #1;
    chk("rst_mid_busy", busy_of(w), 0);
    chk("rst_mid_done", done_of(w), 0);
    chk("rst_mid_result", res_of(w), 0);
    @(posedge clk); #1;
    set_rst(w, 1'b0);
    #1 chk("rst_idle_busy", busy_of(w), 0);
  endtask

  task automatic suite(input bit w);
    logic [63:0] ones, mn;
    int ml, dl;
    ones = w ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    mn   = w ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
    ml   = w ? 1 : 2;
    dl   = w ? 65 : 33;
    // ones - k encodes -(k+1) at the instance width
    run_op(w, 3'b000, 64'd7, ones - 2,  ones - 20, ml + 1);  // 7 * -3 = -21
    run_op(w, 3'b011, ones,  ones,      ones - 1,  ml + 1);  // MULHU max*max
    run_op(w, 3'b001, mn,    mn,        mn >> 1,   ml + 1);  // MULH min*min
    run_op(w, 3'b010, ones,  ones,      ones,      ml + 1);  // MULHSU -1 * max
    run_op(w, 3'b100, ones - 19, 64'd3, ones - 5,  dl);      // -20/3 = -6
    run_op(w, 3'b110, ones - 19, 64'd3, ones - 1,  dl);      // -20%3 = -2
    run_op(w, 3'b101, 64'd100, 64'd7,   64'd14,    dl);
    run_op(w, 3'b111, 64'd100, 64'd7,   64'd2,     dl);
    run_op(w, 3'b101, 64'd5,   64'd0,   ones,      1);
    run_op(w, 3'b110, 64'd5,   64'd0,   64'd5,     1);
    run_op(w, 3'b100, mn,      ones,    mn,        1);
    run_op(w, 3'b110, mn,      ones,    64'd0,     1);
    flush_test(w, w ? 64 : 32);
    run_op(w, 3'b101, 64'd100, 64'd7,   64'd14,    dl);
    idle_flush_test(w);
    run_op(w, 3'b000, 64'd6,   64'd7,   64'd42,    ml + 1);
    reset_test(w);
    run_op(w, 3'b100, ones - 19, 64'd3, ones - 5,  dl);
  endtask

  initial begin
    rst32 = 1'b1; rst64 = 1'b1;
    start32 = 1'b0; start64 = 1'b0;
    flush32 = 1'b0; flush64 = 1'b0;
    op = 3'b000; a = '0; b = '0;
    #1;
    chk("reset_busy32", busy32, 0);
    chk("reset_done32", done32, 0);
    chk("reset_result32", {32'b0, res32}, 0);
    chk("reset_busy64", busy64, 0);
    chk("reset_done64", done64, 0);
    chk("reset_result64", res64, 0);
    repeat (2) @(posedge clk);
    #1;
    rst32 = 1'b0; rst64 = 1'b0;
    @(posedge clk); #1;
    suite(1'b0);
    suite(1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("pending32", 64'(q32.size()), 0);
    chk("pending64", 64'(q64.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
